ram_arbiter: RTL

Round-robin arbiter and sequencer that shares the single-ported RAM among NREQ requesters. The default NREQ=4 maps to icache0, dcache0, icache1 and dcache1. It sits between the cache/coherence layer and the RAM model and owns ramREN, ramWEN, ramaddr and ramstore. It supports locked multi-beat bursts (cache block fills and writebacks), RAM error reporting and a watchdog timeout.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/rr_picker.sv | 25 ++
 rtl/ram_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types plus the RAM arbiter state encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic {IDLE, OWN} arb_state_t;
    localparam int ARB_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin search for the first requester after rr_ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);
    logic [IDW-1:0] j;
    // Walk from farthest to nearest so the nearest hit after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin owner of the single-ported RAM with locked bursts,
// error reporting and a per-beat watchdog.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wen,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*32-1:0] addr,
    input  logic [NREQ*32-1:0] store,
    output logic [NREQ-1:0]   rwait,
    output logic [31:0]       load,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate,
    output logic              gnt_valid,
    output logic [IDW-1:0]    gnt_id,
    output logic              err,
    output logic [IDW-1:0]    err_id
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d, gnt_q, gnt_d, err_id_q;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           found, own, greq, done, abort;
    logic [IDW-1:0] pick;
    ramstate_t      rs;
    word_t          g_addr, g_store;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req(req), .rr_ptr(rr_q), .found(found), .idx(pick)
    );

    always_comb begin
        g_addr  = '0;
        g_store = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IDW'(i)) begin
                g_addr  = addr[i*32 +: 32];
                g_store = store[i*32 +: 32];
            end
        end
    end

    assign rs    = ramstate_t'(ramstate);
    assign own   = state_q == OWN;
    assign greq  = own && req[gnt_q];
    assign done  = greq && rs == ACCESS;
    assign abort = greq && rs != ACCESS && (rs == ERROR || wdog_q == WDW'(TIMEOUT - 1));

    always_comb begin
        ramREN    = greq && !wen[gnt_q];
        ramWEN    = greq && wen[gnt_q];
        ramaddr   = own ? g_addr : '0;
        ramstore  = own ? g_store : '0;
        rwait     = req & ~(NREQ'(done || abort) << gnt_q);
        load      = ramload;
        gnt_valid = own;
        gnt_id    = gnt_q;
        err       = abort;
        err_id    = abort ? gnt_q : err_id_q;
    end

    // Any release (beat end, abort, dropped request) demotes the owner to lowest priority.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        wdog_d  = '0;
        if (!own) begin
            state_d = found ? OWN : IDLE;
            gnt_d   = found ? pick : gnt_q;
        end else if (!greq || abort || (done && !lock[gnt_q])) begin
            state_d = IDLE;
            rr_d    = gnt_q;
        end else if (!done) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_q     <= IDW'(NREQ - 1);
            gnt_q    <= '0;
            wdog_q   <= '0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            wdog_q   <= wdog_d;
            err_id_q <= err_id;
        end
    end
endmodule
